// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment capture path.
// seg7_t is abcdefg with bit6 = a and bit0 = g, active-high (1 = segment lit).
package seg7_pkg;

    localparam int unsigned SEG_W     = 7;
    localparam int unsigned HEX_W     = 4;
    localparam int unsigned ERR_CNT_W = 8;

    typedef logic [SEG_W-1:0] seg7_t;

    localparam seg7_t GLYPH_0 = 7'b1111110;
    localparam seg7_t GLYPH_1 = 7'b0110000;
    localparam seg7_t GLYPH_2 = 7'b1101101;
    localparam seg7_t GLYPH_3 = 7'b1111001;
    localparam seg7_t GLYPH_4 = 7'b0110011;
    localparam seg7_t GLYPH_5 = 7'b1011011;
    localparam seg7_t GLYPH_6 = 7'b1011111;
    localparam seg7_t GLYPH_7 = 7'b1110000;
    localparam seg7_t GLYPH_8 = 7'b1111111;
    localparam seg7_t GLYPH_9 = 7'b1111011;
    localparam seg7_t GLYPH_A = 7'b1110111;
    localparam seg7_t GLYPH_B = 7'b0011111;
    localparam seg7_t GLYPH_C = 7'b1001110;
    localparam seg7_t GLYPH_D = 7'b0111101;
    localparam seg7_t GLYPH_E = 7'b1001111;
    localparam seg7_t GLYPH_F = 7'b1000111;

    localparam seg7_t SEG_BLANK = 7'h00;

    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'hFF;

endpackage : seg7_pkg

// File: rtl/seg7_glyph_lookup.sv
// Combinational reverse lookup of an active-high abcdefg glyph to its hex digit.
// Ports:
//   glyph_i  active-high segment pattern
//   hex_o    decoded digit (0 when no match)
//   hit_o    1 when glyph_i is one of the 16 hex glyphs
module seg7_glyph_lookup
    import seg7_pkg::*;
(
    input  seg7_t            glyph_i,
    output logic [HEX_W-1:0] hex_o,
    output logic             hit_o
);

    always_comb begin
        hex_o = '0;
        hit_o = 1'b1;
        case (glyph_i)
            GLYPH_0: hex_o = 4'h0;
            GLYPH_1: hex_o = 4'h1;
            GLYPH_2: hex_o = 4'h2;
            GLYPH_3: hex_o = 4'h3;
            GLYPH_4: hex_o = 4'h4;
            GLYPH_5: hex_o = 4'h5;
            GLYPH_6: hex_o = 4'h6;
            GLYPH_7: hex_o = 4'h7;
            GLYPH_8: hex_o = 4'h8;
            GLYPH_9: hex_o = 4'h9;
            GLYPH_A: hex_o = 4'hA;
            GLYPH_B: hex_o = 4'hB;
            GLYPH_C: hex_o = 4'hC;
            GLYPH_D: hex_o = 4'hD;
            GLYPH_E: hex_o = 4'hE;
            GLYPH_F: hex_o = 4'hF;
            default: hit_o = 1'b0;
        endcase
    end

endmodule : seg7_glyph_lookup

// File: rtl/seg7_capture_decoder.sv
// Samples an asynchronous active-low 7-segment bus, filters glitches, decodes
// each newly accepted stable glyph to hex and checks +1 mod 16 count order.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   seg         segment bus, active-low, bit6=a .. bit0=g, asynchronous to clk
//   hex         last successfully decoded value
//   hex_valid   one-cycle pulse per newly accepted valid glyph
//   blank       level, accepted pattern has all segments off
//   pat_err     one-cycle pulse when an accepted pattern is not a glyph
//   seq_err     one-cycle pulse when a valid value breaks the count order
//   err_cnt     saturating count of pat_err + seq_err events
module seg7_capture_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter bit          SEQ_CHECK     = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [SEG_W-1:0]     seg,
    output logic [HEX_W-1:0]     hex,
    output logic                 hex_valid,
    output logic                 blank,
    output logic                 pat_err,
    output logic                 seq_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int unsigned   STAB_W    = 8;
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [SEG_W-1:0]  BUS_IDLE  = 7'h7F;

    // Sync flops and filter state stay in bus polarity (all-ones = all off).
    logic [SEG_W-1:0]     s1_q, s2_q;
    logic [SEG_W-1:0]     cand_q, cand_d;
    logic [SEG_W-1:0]     accepted_q, accepted_d;
    logic [STAB_W-1:0]    stab_q, stab_d;
    logic [HEX_W-1:0]     hex_q, hex_d;
    logic                 hex_valid_q, hex_valid_d;
    logic                 blank_q, blank_d;
    logic                 pat_err_q, pat_err_d;
    logic                 seq_err_q, seq_err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 have_prev_q, have_prev_d;

    seg7_t            cand_act;
    logic [HEX_W-1:0] lut_hex;
    logic             lut_hit;
    logic             accept;

    assign cand_act = seg7_t'(~cand_q);

    seg7_glyph_lookup u_lookup (
        .glyph_i (cand_act),
        .hex_o   (lut_hex),
        .hit_o   (lut_hit)
    );

    // Two-flop synchronizer on the raw bus
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= BUS_IDLE;
            s2_q <= BUS_IDLE;
        end else begin
            s1_q <= seg;
            s2_q <= s1_q;
        end
    end

    // Stability filter, decode and error tally
    always_comb begin
        cand_d      = cand_q;
        stab_d      = stab_q;
        accepted_d  = accepted_q;
        hex_d       = hex_q;
        hex_valid_d = 1'b0;
        blank_d     = blank_q;
        pat_err_d   = 1'b0;
        seq_err_d   = 1'b0;
        err_cnt_d   = err_cnt_q;
        have_prev_d = have_prev_q;
        accept      = 1'b0;

        if (s2_q != cand_q) begin
            cand_d = s2_q;
            stab_d = '0;
        end else begin
            if (stab_q < STAB_LAST) begin
                stab_d = stab_q + STAB_W'(1);
            end
            // Returning to the pattern already accepted is not a new event
            accept = (stab_q == STAB_LAST) && (cand_q != accepted_q);
        end

        if (accept) begin
            accepted_d = cand_q;
            if (cand_act == SEG_BLANK) begin
                blank_d     = 1'b1;
                have_prev_d = 1'b0;
            end else if (lut_hit) begin
                hex_d       = lut_hex;
                hex_valid_d = 1'b1;
                blank_d     = 1'b0;
                // hex_q still holds the previous decoded value; 4-bit add wraps F->0
                if (SEQ_CHECK && have_prev_q && (lut_hex != HEX_W'(hex_q + HEX_W'(1)))) begin
                    seq_err_d = 1'b1;
                end
                have_prev_d = 1'b1;
            end else begin
                pat_err_d   = 1'b1;
                blank_d     = 1'b0;
                have_prev_d = 1'b0;
            end
        end

        if ((pat_err_d || seq_err_d) && (err_cnt_q != ERR_CNT_MAX)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_q      <= BUS_IDLE;
            accepted_q  <= BUS_IDLE;
            stab_q      <= '0;
            hex_q       <= '0;
            hex_valid_q <= 1'b0;
            blank_q     <= 1'b1;
            pat_err_q   <= 1'b0;
            seq_err_q   <= 1'b0;
            err_cnt_q   <= '0;
            have_prev_q <= 1'b0;
        end else begin
            cand_q      <= cand_d;
            accepted_q  <= accepted_d;
            stab_q      <= stab_d;
            hex_q       <= hex_d;
            hex_valid_q <= hex_valid_d;
            blank_q     <= blank_d;
            pat_err_q   <= pat_err_d;
            seq_err_q   <= seq_err_d;
            err_cnt_q   <= err_cnt_d;
            have_prev_q <= have_prev_d;
        end
    end

    assign hex       = hex_q;
    assign hex_valid = hex_valid_q;
    assign blank     = blank_q;
    assign pat_err   = pat_err_q;
    assign seq_err   = seq_err_q;
    assign err_cnt   = err_cnt_q;

endmodule : seg7_capture_decoder

// File: tb/tb_seg7_capture_decoder.sv
// Bench for seg7_capture_decoder: instance 0 with sequence checking, instance 1
// without, both fed the same bus. A pattern-level model predicts each accept.
module tb_seg7_capture_decoder;

    localparam int unsigned SC  = 4;
    localparam int          LAT = SC + 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] seg;

    logic [1:0] o_hv, o_pe, o_se, o_blank;
    logic [3:0] o_hex [2];
    logic [7:0] o_err [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seg7_capture_decoder #(.STABLE_CYCLES(SC), .SEQ_CHECK(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .seg(seg),
        .hex(o_hex[0]), .hex_valid(o_hv[0]), .blank(o_blank[0]),
        .pat_err(o_pe[0]), .seq_err(o_se[0]), .err_cnt(o_err[0])
    );

    seg7_capture_decoder #(.STABLE_CYCLES(SC), .SEQ_CHECK(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .seg(seg),
        .hex(o_hex[1]), .hex_valid(o_hv[1]), .blank(o_blank[1]),
        .pat_err(o_pe[1]), .seq_err(o_se[1]), .err_cnt(o_err[1])
    );

    // Active-high abcdefg glyphs for 0..F
    logic [6:0] glyph_tab [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    // Model state (bus-polarity accepted pattern shared, rest per instance)
    logic [6:0] m_acc;
    bit         m_have  [2];
    int         m_prev  [2];
    int         m_err   [2];
    logic [3:0] m_hex   [2];
    bit         m_blank [2];
    bit         e_valid, e_pat;
    bit         e_seq   [2];

    function automatic void model_reset();
        m_acc = 7'h7F;
        for (int i = 0; i < 2; i++) begin
            m_have[i] = 0; m_prev[i] = 0; m_err[i] = 0;
            m_hex[i] = 4'h0; m_blank[i] = 1;
        end
    endfunction

    function automatic void model_step(input logic [6:0] p);
        logic [6:0] a;
        int v;
        e_valid = 0; e_pat = 0; e_seq[0] = 0; e_seq[1] = 0;
        if (p == m_acc) return;
        m_acc = p;
        a = ~p;
        v = -1;
        for (int g = 0; g < 16; g++) if (glyph_tab[g] == a) v = g;
        for (int i = 0; i < 2; i++) begin
            if (a == 7'h00) begin
                m_blank[i] = 1; m_have[i] = 0;
            end else if (v >= 0) begin
                e_valid = 1; m_blank[i] = 0;
                if (i == 0 && m_have[i] && v != (m_prev[i] + 1) % 16) begin
                    e_seq[i] = 1;
                    if (m_err[i] < 255) m_err[i]++;
                end
                m_have[i] = 1; m_prev[i] = v; m_hex[i] = 4'(v);
            end else begin
                e_pat = 1; m_blank[i] = 0; m_have[i] = 0;
                if (m_err[i] < 255) m_err[i]++;
            end
        end
    endfunction

    function automatic logic [6:0] bus_of(input int v);
        logic [6:0] g;
        g = glyph_tab[v % 16];
        return ~g;
    endfunction

    // Drive pattern p for hold cycles (hold <= SC-1 is a glitch, hold >= 8 is
    // a full accept window) and check both instances against the model.
    task automatic drive_pat(input logic [6:0] p, input int hold, input string tag);
        int hv [2]; int pe [2]; int se [2]; int at [2];
        e_valid = 0; e_pat = 0; e_seq[0] = 0; e_seq[1] = 0;
        if (hold >= 8) model_step(p);
        for (int i = 0; i < 2; i++) begin hv[i] = 0; pe[i] = 0; se[i] = 0; at[i] = 0; end
        seg = p;
        for (int k = 1; k <= hold; k++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (o_hv[i]) hv[i]++;
                if (o_pe[i]) pe[i]++;
                if (o_se[i]) se[i]++;
                if ((o_hv[i] || o_pe[i] || o_se[i]) && at[i] == 0) at[i] = k;
            end
        end
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (hv[i] !== int'(e_valid)) begin
                n_fail++;
                $display("FAIL %s dut%0d hex_valid pulses: got %0d want %0d", tag, i, hv[i], int'(e_valid));
            end
            n_checks++;
            if (pe[i] !== int'(e_pat)) begin
                n_fail++;
                $display("FAIL %s dut%0d pat_err pulses: got %0d want %0d", tag, i, pe[i], int'(e_pat));
            end
            n_checks++;
            if (se[i] !== int'(e_seq[i])) begin
                n_fail++;
                $display("FAIL %s dut%0d seq_err pulses: got %0d want %0d", tag, i, se[i], int'(e_seq[i]));
            end
            if (e_valid || e_pat) begin
                n_checks++;
                if (at[i] !== LAT) begin
                    n_fail++;
                    $display("FAIL %s dut%0d pulse latency: got %0d want %0d", tag, i, at[i], LAT);
                end
            end
            n_checks++;
            if (o_hex[i] !== m_hex[i]) begin
                n_fail++;
                $display("FAIL %s dut%0d hex: got %h want %h", tag, i, o_hex[i], m_hex[i]);
            end
            n_checks++;
            if (o_blank[i] !== 1'(m_blank[i])) begin
                n_fail++;
                $display("FAIL %s dut%0d blank: got %b want %b", tag, i, o_blank[i], m_blank[i]);
            end
            n_checks++;
            if (o_err[i] !== 8'(m_err[i])) begin
                n_fail++;
                $display("FAIL %s dut%0d err_cnt: got %0d want %0d", tag, i, o_err[i], m_err[i]);
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (o_hex[i] !== 4'h0 || o_blank[i] !== 1'b1 || o_err[i] !== 8'h00 ||
                o_hv[i] !== 1'b0 || o_pe[i] !== 1'b0 || o_se[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL %s dut%0d reset values: got hex=%h blank=%b err=%0d hv=%b pe=%b se=%b want 0,1,0,0,0,0",
                         tag, i, o_hex[i], o_blank[i], o_err[i], o_hv[i], o_pe[i], o_se[i]);
            end
        end
    endtask

    task automatic test_reset();
        int pulses;
        pulses = 0;
        rst_n = 1'b0;
        model_reset();
        for (int k = 0; k < 8; k++) begin
            seg = 7'($urandom);
            @(posedge clk); #1;
            if (o_hv != 2'b00 || o_pe != 2'b00 || o_se != 2'b00) pulses++;
        end
        n_checks++;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL reset pulses during reset: got %0d want 0", pulses);
        end
        check_reset_values("reset");
        seg = 7'h7F;
        @(negedge clk);
        rst_n = 1'b1;
        drive_pat(7'h7F, 12, "idle_after_reset");
    endtask

    task automatic test_clean_glyph();
        drive_pat(bus_of(0), 10, "clean_glyph0");
    endtask

    task automatic test_glitch();
        drive_pat(bus_of(1), 3, "glitch_1");
        drive_pat(bus_of(0), 10, "glitch_return0");
    endtask

    task automatic test_count_sweep();
        drive_pat(7'h7F, 10, "sweep_blank");
        for (int v = 0; v <= 16; v++) drive_pat(bus_of(v), 20, "sweep");
    endtask

    task automatic test_order_error();
        drive_pat(7'h7F, 10, "order_blank");
        drive_pat(bus_of(0), 10, "order_0");
        drive_pat(bus_of(2), 10, "order_2");
    endtask

    task automatic test_invalid();
        drive_pat(~7'b0000001, 10, "invalid_g");
        drive_pat(bus_of(5), 10, "after_invalid_5");
    endtask

    task automatic test_random();
        logic [6:0] p, last;
        int hold;
        last = seg;
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 4))
                0, 1:    p = bus_of(int'($urandom_range(0, 15)));
                2:       p = bus_of(m_prev[0] + 1);
                3:       p = 7'h7F;
                default: p = 7'($urandom);
            endcase
            if (p == last) p = p ^ 7'h40;
            hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, SC - 1))
                                                : int'($urandom_range(8, 14));
            drive_pat(p, hold, "random");
            last = p;
        end
    endtask

    task automatic test_saturation();
        for (int n = 0; n < 300; n++) begin
            drive_pat(~7'b0000001, 8, "sat_invalid");
            drive_pat(7'h7F, 8, "sat_blank");
        end
    endtask

    task automatic test_async_reset();
        drive_pat(bus_of(7), 3, "partial_7");
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        model_reset();
        seg = 7'h7F;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("async_reset_hold");
        rst_n = 1'b1;
        drive_pat(7'h7F, 12, "after_async_idle");
        drive_pat(bus_of(7), 10, "after_async_7");
    endtask

    initial begin
        seg   = 7'h7F;
        rst_n = 1'b0;
        model_reset();
        test_reset();
        test_clean_glyph();
        test_glitch();
        test_count_sweep();
        test_order_error();
        test_invalid();
        test_random();
        test_saturation();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_seg7_capture_decoder
